// File: rtl/fruit_class_vote_if.sv
// Pixel-side bundle for fruit_class_vote: class flags and sync/DE in, vote results out.
interface fruit_class_vote_if #(
    parameter int CNT_W   = 20,
    parameter int N_CLASS = 12
);
    logic [N_CLASS-1:0] i_class_n;
    logic               i_hsync;
    logic               i_vsync;
    logic               i_de;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_de;
    logic [3:0]         o_class_raw;
    logic [3:0]         o_class;
    logic [CNT_W-1:0]   o_count;
    logic               o_valid;
    logic               o_busy;

    modport master (
        output i_class_n, i_hsync, i_vsync, i_de,
        input  o_hsync, o_vsync, o_de, o_class_raw, o_class, o_count, o_valid, o_busy
    );

    modport slave (
        input  i_class_n, i_hsync, i_vsync, i_de,
        output o_hsync, o_vsync, o_de, o_class_raw, o_class, o_count, o_valid, o_busy
    );
endinterface

// File: rtl/fruit_class_vote.sv
// Per-frame class histogram, serial argmax with minimum-area gate, and a
// consecutive-frame stability filter producing the recognised-fruit code.
module fruit_class_vote #(
    parameter int CNT_W    = 20,
    parameter int N_CLASS  = 12,
    parameter int MIN_PIX  = 2000,
    parameter int STABLE_N = 3,
    parameter int VS_POL   = 1
) (
    input logic             pixelclk,
    input logic             reset_n,
    fruit_class_vote_if.slave bus
);

    localparam logic        VS_ACT    = (VS_POL != 0);
    localparam logic [3:0]  NONE      = 4'hF;
    localparam logic [3:0]  LAST_IDX  = 4'(N_CLASS - 1);
    localparam logic [31:0] MIN_PIX_U = 32'(MIN_PIX);
    localparam logic [2:0]  STAB_THR  = 3'(STABLE_N);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        ACCUM,
        COMPARE,
        PUBLISH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] live_q   [N_CLASS];
    logic [CNT_W-1:0] live_d   [N_CLASS];
    logic [CNT_W-1:0] shadow_q [N_CLASS];
    logic [3:0]       idx_q;
    logic [3:0]       best_q;
    logic [CNT_W-1:0] bestcnt_q;
    logic [3:0]       cand_q;
    logic [2:0]       stab_q;
    logic             vs_d_q;
    logic             hs_q, vs_q, de_q;
    logic [3:0]       class_raw_q, class_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q, busy_q;

    logic [N_CLASS-1:0] hit;
    logic               frame_edge;
    logic               snap;
    logic [CNT_W-1:0]   shadow_cur;
    logic               take;
    logic [3:0]         best_d;
    logic [CNT_W-1:0]   bestcnt_d;
    logic [3:0]         raw_d;
    logic [2:0]         stab_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign hit        = {N_CLASS{bus.i_de}} & ~bus.i_class_n;
    assign frame_edge = (bus.i_vsync == VS_ACT) && (vs_d_q != VS_ACT);
    // Edges seen while COMPARE walks the shadows are deliberately dropped.
    assign snap       = frame_edge && (state_q == ACCUM || state_q == PUBLISH);

    always_comb begin
        for (int k = 0; k < N_CLASS; k++) begin
            live_d[k] = sat_inc(live_q[k], hit[k]);
            if (state_q == WAIT_FIRST) begin
                live_d[k] = frame_edge ? CNT_W'(hit[k]) : '0;
            end else if (snap) begin
                live_d[k] = CNT_W'(hit[k]);
            end
        end
    end

    assign shadow_cur = shadow_q[idx_q];
    assign take       = shadow_cur > bestcnt_q;
    assign best_d     = take ? idx_q : best_q;
    assign bestcnt_d  = take ? shadow_cur : bestcnt_q;
    assign raw_d      = (32'(bestcnt_d) >= MIN_PIX_U) ? best_d : NONE;
    assign stab_d     = (raw_d != cand_q) ? 3'd1 :
                        (stab_q == 3'd7)  ? 3'd7 : stab_q + 3'd1;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_FIRST;
            for (int k = 0; k < N_CLASS; k++) begin
                live_q[k]   <= '0;
                shadow_q[k] <= '0;
            end
            idx_q       <= '0;
            best_q      <= NONE;
            bestcnt_q   <= '0;
            cand_q      <= NONE;
            stab_q      <= '0;
            vs_d_q      <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            class_raw_q <= NONE;
            class_q     <= NONE;
            count_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vs_d_q  <= bus.i_vsync;
            hs_q    <= bus.i_hsync;
            vs_q    <= bus.i_vsync;
            de_q    <= bus.i_de;
            valid_q <= 1'b0;
            for (int k = 0; k < N_CLASS; k++) begin
                live_q[k] <= live_d[k];
                if (snap) shadow_q[k] <= live_q[k];
            end

            case (state_q)
                WAIT_FIRST: begin
                    if (frame_edge) state_q <= ACCUM;
                end
                ACCUM, PUBLISH: begin
                    state_q <= ACCUM;
                    if (frame_edge) begin
                        state_q   <= COMPARE;
                        idx_q     <= '0;
                        best_q    <= NONE;
                        bestcnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                COMPARE: begin
                    best_q    <= best_d;
                    bestcnt_q <= bestcnt_d;
                    idx_q     <= idx_q + 4'd1;
                    // Final step: results and filter update land together so they show in PUBLISH.
                    if (idx_q == LAST_IDX) begin
                        state_q     <= PUBLISH;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        class_raw_q <= raw_d;
                        count_q     <= bestcnt_d;
                        cand_q      <= raw_d;
                        stab_q      <= stab_d;
                        if (stab_d >= STAB_THR) class_q <= raw_d;
                    end
                end
                default: state_q <= WAIT_FIRST;
            endcase
        end
    end

    assign bus.o_hsync     = hs_q;
    assign bus.o_vsync     = vs_q;
    assign bus.o_de        = de_q;
    assign bus.o_class_raw = class_raw_q;
    assign bus.o_class     = class_q;
    assign bus.o_count     = count_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_fruit_class_vote.sv
// Scoreboard bench: two DUTs (wide and 4-bit counters) share one 16x8 pixel stream.
module tb_fruit_class_vote;

    localparam int MINP = 10;
    localparam int STAB = 2;

    typedef struct {
        int raw;
        int cnt;
        int cls;
        int ecyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] cls_n;
    logic        hs, vs, de;

    fruit_class_vote_if #(.CNT_W(20), .N_CLASS(12)) bus_a ();
    fruit_class_vote_if #(.CNT_W(4),  .N_CLASS(12)) bus_b ();

    assign bus_a.i_class_n = cls_n;
    assign bus_a.i_hsync   = hs;
    assign bus_a.i_vsync   = vs;
    assign bus_a.i_de      = de;
    assign bus_b.i_class_n = cls_n;
    assign bus_b.i_hsync   = hs;
    assign bus_b.i_vsync   = vs;
    assign bus_b.i_de      = de;

    fruit_class_vote #(.CNT_W(20), .N_CLASS(12), .MIN_PIX(MINP), .STABLE_N(STAB), .VS_POL(1)) dut_a (
        .pixelclk(clk), .reset_n(rst_n), .bus(bus_a.slave));
    fruit_class_vote #(.CNT_W(4), .N_CLASS(12), .MIN_PIX(MINP), .STABLE_N(STAB), .VS_POL(1)) dut_b (
        .pixelclk(clk), .reset_n(rst_n), .bus(bus_b.slave));

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t mon_a, mon_b;
    int   mcnt[12];
    int   maxc[2] = '{1048575, 15};
    int   cand[2], stab[2], ocls[2];
    bit   armed, prev_vs;
    int   last_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        armed   = 1'b0;
        prev_vs = 1'b0;
        last_e  = -1000;
        for (int d = 0; d < 2; d++) begin
            cand[d] = 15;
            stab[d] = 0;
            ocls[d] = 15;
        end
        for (int k = 0; k < 12; k++) mcnt[k] = 0;
    endtask

    task automatic predict(input int d, output exp_t e);
        int best = 15;
        int bc = 0;
        int v;
        for (int k = 0; k < 12; k++) begin
            v = (mcnt[k] > maxc[d]) ? maxc[d] : mcnt[k];
            if (v > bc) begin
                bc   = v;
                best = k;
            end
        end
        e.raw = (bc >= MINP) ? best : 15;
        e.cnt = bc;
        if (e.raw == cand[d]) stab[d] = (stab[d] == 7) ? 7 : stab[d] + 1;
        else begin
            cand[d] = e.raw;
            stab[d] = 1;
        end
        if (stab[d] >= STAB) ocls[d] = cand[d];
        e.cls  = ocls[d];
        e.ecyc = cyc;
    endtask

    task automatic step(input bit d_de, input logic [11:0] d_cls, input bit d_hs, input bit d_vs);
        exp_t e;
        @(posedge clk);
        #1;
        de    = d_de;
        cls_n = d_cls;
        hs    = d_hs;
        vs    = d_vs;
        if (d_vs && !prev_vs) begin
            if (!armed) begin
                armed = 1'b1;
                for (int k = 0; k < 12; k++) mcnt[k] = 0;
            end else if (cyc - last_e >= 13) begin
                predict(0, e);
                qa.push_back(e);
                predict(1, e);
                qb.push_back(e);
                last_e = cyc;
                for (int k = 0; k < 12; k++) mcnt[k] = 0;
            end
        end
        prev_vs = d_vs;
        if (armed && d_de)
            for (int k = 0; k < 12; k++) if (!d_cls[k]) mcnt[k]++;
    endtask

    task automatic frame(input int ca, input int na, input int cb, input int nb);
        for (int ln = 0; ln < 8; ln++) begin
            for (int px = 0; px < 16; px++) begin
                int p;
                logic [11:0] c;
                p = ln * 16 + px;
                c = '1;
                if (p < na) c[ca] = 1'b0;
                else if (p < na + nb) c[cb] = 1'b0;
                step(1'b1, c, 1'b0, 1'b0);
            end
            for (int b = 0; b < 4; b++) step(1'b0, '1, 1'b1, 1'b0);
        end
    endtask

    task automatic vedge();
        for (int i = 0; i < 3; i++) step(1'b0, '1, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, '1, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_raw_a"},   bus_a.o_class_raw, 15);
        check({pfx, "_class_a"}, bus_a.o_class, 15);
        check({pfx, "_count_a"}, bus_a.o_count, 0);
        check({pfx, "_vb_a"},    {bus_a.o_valid, bus_a.o_busy}, 0);
        check({pfx, "_sync_a"},  {bus_a.o_hsync, bus_a.o_vsync, bus_a.o_de}, 0);
        check({pfx, "_raw_b"},   bus_b.o_class_raw, 15);
        check({pfx, "_count_b"}, bus_b.o_count, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.o_valid) begin
            if (qa.size() == 0) check("a_spurious_valid", 1, 0);
            else begin
                mon_a = qa.pop_front();
                check("a_raw",     bus_a.o_class_raw, mon_a.raw);
                check("a_count",   bus_a.o_count, mon_a.cnt);
                check("a_class",   bus_a.o_class, mon_a.cls);
                check("a_latency", cyc - mon_a.ecyc, 13);
            end
        end
        if (rst_n && bus_b.o_valid) begin
            if (qb.size() == 0) check("b_spurious_valid", 1, 0);
            else begin
                mon_b = qb.pop_front();
                check("b_raw",     bus_b.o_class_raw, mon_b.raw);
                check("b_count",   bus_b.o_count, mon_b.cnt);
                check("b_class",   bus_b.o_class, mon_b.cls);
                check("b_latency", cyc - mon_b.ecyc, 13);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        de    = 1'b0;
        cls_n = '1;
        hs    = 1'b0;
        vs    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // sync path: one-clock registered copy
        step(1'b1, '1, 1'b1, 1'b0);
        @(negedge clk);
        check("sync_before", {bus_a.o_hsync, bus_a.o_vsync, bus_a.o_de}, 3'b000);
        step(1'b0, '1, 1'b0, 1'b0);
        @(negedge clk);
        check("sync_after", {bus_a.o_hsync, bus_a.o_vsync, bus_a.o_de}, 3'b101);

        // T1: partial frame discarded, then two identical frames
        frame(3, 5, 8, 5);
        vedge();
        frame(3, 60, 8, 40);
        vedge();
        frame(3, 60, 8, 40);
        vedge();

        // T2: tie goes to lowest index
        frame(2, 50, 9, 50);
        vedge();

        // T3: below minimum area, twice
        frame(5, 9, 0, 0);
        vedge();
        frame(5, 9, 0, 0);
        vedge();

        // T4: 20 px saturate the 4-bit instance
        frame(1, 20, 0, 0);
        vedge();

        // T5: pixel in edge cycle, second edge at E+5, busy window
        frame(0, 12, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(i == 0, (i == 0) ? 12'hFFE : 12'hFFF, 1'b0, (i <= 2) || (i >= 5 && i <= 7));
            @(negedge clk);
            check("t5_busy", bus_a.o_busy, (i >= 1 && i <= 12));
        end
        repeat (8) step(1'b0, '1, 1'b0, 1'b0);
        frame(0, 12, 0, 0);
        vedge();

        // T6: reset at compare step 6
        frame(4, 20, 0, 0);
        for (int i = 0; i < 7; i++) step(1'b0, '1, 1'b0, i <= 2);
        step(1'b0, '1, 1'b0, 1'b0);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        model_reset();
        #1;
        check_reset_outputs("t6");
        step(1'b0, '1, 1'b0, 1'b0);
        step(1'b0, '1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (20) step(1'b0, '1, 1'b0, 1'b0);
        check("t6_quiet_raw", bus_a.o_class_raw, 15);
        frame(6, 30, 0, 0);
        vedge();
        check("t6_wait_first_count", bus_a.o_count, 0);
        frame(6, 30, 0, 0);
        vedge();

        repeat (20) step(1'b0, '1, 1'b0, 1'b0);
        check("pending_a", qa.size(), 0);
        check("pending_b", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fruit_class_vote.md
Name: fruit_class_vote

Overview:
- Downstream of the YCbCr threshold classifier.
- Consumes the 12 per-pixel active-low class flags with the matching sync/DE timing.
- Counts pixels per class over each video frame. At frame end, picks the dominant class (argmax above a minimum area) and applies a multi-frame stability filter.
- Presents a 4-bit recognised-fruit code to the display/overlay and LED logic.

Parameters:
- CNT_W, 20, width of each per-class pixel counter (saturating).
- N_CLASS, 12, number of class inputs; fixed at 12 for this release.
- MIN_PIX, 2000, minimum winning pixel count for a valid recognition.
- STABLE_N, 3, consecutive identical raw results required before o_class updates (range 1..7).
- VS_POL, 1, active level of i_vsync.

Ports:
- pixelclk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- i_class_n  in  12  bit k low = pixel belongs to class k (k=0..11)
- i_hsync  in  1  horizontal sync, passed through
- i_vsync  in  1  vertical sync; frame boundary source
- i_de  in  1  pixel valid
- o_hsync  out  1  i_hsync delayed 1 clock
- o_vsync  out  1  i_vsync delayed 1 clock
- o_de  out  1  i_de delayed 1 clock
- o_class_raw  out  4  argmax result of the last completed frame; 4'hF = none
- o_class  out  4  stability-filtered result; 4'hF = none
- o_count  out  CNT_W  pixel count of the winning class of the last frame
- o_valid  out  1  one-cycle pulse when o_class_raw/o_count update
- o_busy  out  1  high while in COMPARE

Behaviour:
- Reset (async, reset_n low):
  - All counters and shadows = 0.
  - o_class_raw = o_class = 4'hF; o_count = 0.
  - o_valid = o_busy = 0; sync/de outputs = 0.
  - FSM = WAIT_FIRST. Stability counter = 0, candidate = 4'hF.
- Frame-end edge:
  - vs_d registers i_vsync. Edge E is the cycle where i_vsync==VS_POL and vs_d!=VS_POL.
- Counting (ACCUM, and during COMPARE):
  - On every cycle with i_de==1, each counter k with i_class_n[k]==0 increments.
  - Multiple low bits in one pixel increment each matching counter.
  - Counters saturate at all-ones (no wrap).
- FSM WAIT_FIRST:
  - Counters are held at 0 and ignore i_de.
  - At the first edge E: go to ACCUM, no o_valid. The partial frame after reset is discarded.
- FSM ACCUM:
  - At edge E: shadow[k] <= live[k]; live counters clear to 0 in the same clock.
  - A pixel with i_de==1 in cycle E counts as 1 in the new frame.
  - Go to COMPARE with idx=0, best=4'hF, bestcnt=0. o_busy=1.
- FSM COMPARE:
  - One class per clock, idx 0..11.
  - If shadow[idx] > bestcnt (strict): best=idx, bestcnt=shadow[idx]. Ties therefore go to the lowest index.
  - After idx=11, go to PUBLISH.
  - Edges occurring during COMPARE are ignored: no snapshot and no clear.
- FSM PUBLISH (1 cycle):
  - o_class_raw = (bestcnt >= MIN_PIX) ? best : 4'hF.
  - o_count = bestcnt.
  - o_valid = 1 for this cycle only. o_busy = 0.
  - Return to ACCUM.
  - o_valid rises exactly 13 clocks after cycle E (E+1..E+12 compare, E+13 publish).
- Stability filter, evaluated at PUBLISH:
  - If the new raw result == candidate: stab = min(stab+1, 7). Otherwise candidate = raw, stab = 1.
  - When stab >= STABLE_N, o_class = candidate. Otherwise o_class holds its value.
  - "None" (4'hF) is filtered the same way as real classes.
- Sync path: o_hsync/o_vsync/o_de are registered copies, 1-cycle latency, independent of the FSM.
- Reset asserted mid-frame or mid-COMPARE: immediate return to reset values and WAIT_FIRST. No o_valid is produced for the interrupted frame.

Test Plan:
- Overrides for all tests: 16x8 active frame (128 px/frame), MIN_PIX=10, STABLE_N=2.
- T1: reset, send frame A (counts discarded), then frame B with 60 px class 3, 40 px class 8, 28 px none, then vsync edge.
  - Required: o_valid 13 clocks after the edge; o_class_raw=3, o_count=60.
  - o_class stays F after this frame; it becomes 3 after one more identical frame.
- T2: frame with 50 px class 2 and 50 px class 9.
  - Required: o_class_raw=2 (lowest index wins the tie); o_count=50.
- T3: frame with 9 px class 5, rest none.
  - Required: o_class_raw=F, o_count=9. o_class changes to F only after 2 consecutive such frames.
- T4: with CNT_W=4 override, 20 px class 1 in a frame.
  - Required: o_count=15 (saturated), o_class_raw=1.
- T5: pixel with i_de=1 and class 0 in the edge cycle E.
  - Required: it is excluded from the published count and counted in the next frame's total.
  - Also assert a second vsync edge at E+5: no extra o_valid, and o_busy stays high until E+13.
- T6: reset_n pulsed low at compare step 6.
  - Required: outputs return to reset values immediately, no o_valid follows, and the next vsync edge is treated as WAIT_FIRST (no publish).
